// File: rtl/axis_read.sv
// axis_read: AXI4 read engine feeding a DATA_WIDTH valid/ready stream.
//   Software selects the channel (CFG_ADDR write carrying CFG_ID), then writes
//   a start byte address and a length in stream words to CFG_DATA. The engine
//   issues AR bursts gated by buffer credit, buffers R beats in a FIFO and
//   splits each beat into RATIO stream words, LSB lane first.
// Ports:
//   clk, rst                         clock, async active-high reset
//   cfg_addr/cfg_data/cfg_valid      shared config write bus (registered once)
//   axi_ar*                          AXI4 read address channel
//   axi_r*                           AXI4 read data channel (rlast unused)
//   data/valid/ready                 output stream
//   busy                             transfer in progress
module axis_read #(
  parameter int BUF_AWIDTH     = 9,
  parameter int BURST_MAX      = 16,
  parameter int CFG_ID         = 2,
  parameter int CFG_ADDR       = 23,
  parameter int CFG_DATA       = 25,
  parameter int CFG_AWIDTH     = 5,
  parameter int CFG_DWIDTH     = 32,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_AWIDTH-1:0]     cfg_addr,
  input  logic [CFG_DWIDTH-1:0]     cfg_data,
  input  logic                      cfg_valid,
  input  logic                      axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_arlen,
  output logic                      axi_arvalid,
  input  logic                      axi_rlast,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      busy
);

  localparam int RATIO = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int DEPTH = 1 << BUF_AWIDTH;
  localparam int PW    = BUF_AWIDTH + 1;   // pointers/credit carry a wrap bit
  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int CW    = CFG_DWIDTH;
  localparam logic [LW-1:0] LANE_MAX = LW'(RATIO - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    CONFIG = 4'b0010,
    START  = 4'b0100,
    RUN    = 4'b1000
  } state_t;

  state_t state, state_nx;

  // registered cfg bus
  logic [CFG_AWIDTH-1:0] ca_q;
  logic [CFG_DWIDTH-1:0] cd_q;
  logic                  cv_q;
  logic                  cfg_sel, cfg_wr;
  logic                  cfg_cnt;
  logic [CW-1:0]         start_addr, length;

  // AR side
  logic [AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [CW-1:0]             beats_rem, beats_total;
  logic [PW-1:0]             ar_beats, burst, used, free;
  logic                      ar_hs;

  // buffer and down-converter
  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]             wr_ptr, ld_ptr;
  logic [LW-1:0]             ld_lane;
  logic [CW-1:0]             ld_words, acc_rem;
  logic [AXI_DATA_WIDTH-1:0] ld_beat;
  logic                      ld_go, ld_last, out_last, push, pop, done;

  logic unused_rlast;
  assign unused_rlast = axi_rlast;

  assign cfg_sel = cv_q && (ca_q == CFG_AWIDTH'(CFG_ADDR)) && (cd_q == CW'(CFG_ID));
  assign cfg_wr  = cv_q && (ca_q == CFG_AWIDTH'(CFG_DATA));

  assign beats_total = (length / CW'(RATIO)) +
                       (((length % CW'(RATIO)) != '0) ? CW'(1) : '0);
  assign burst = (beats_rem > CW'(BURST_MAX)) ? PW'(BURST_MAX) : PW'(beats_rem);
  assign free  = PW'(DEPTH) - used;
  assign ar_hs = axi_arvalid && axi_arready;

  assign push    = axi_rvalid && axi_rready && (state == RUN);
  assign ld_beat = mem[ld_ptr[BUF_AWIDTH-1:0]];
  // an entry's last used lane is either its top lane or the transfer's final word
  assign ld_last = (ld_lane == LANE_MAX) || (ld_words == CW'(1));
  assign ld_go   = (state == RUN) && (ld_ptr != wr_ptr) && (ld_words != '0) &&
                   (!valid || ready);
  // credit comes back only once the word leaves the output register
  assign pop     = valid && ready && out_last;
  assign done    = valid && ready && (acc_rem == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cfg_sel) state_nx = CONFIG;
      CONFIG:  if (cfg_wr && cfg_cnt) state_nx = START;
      START:   state_nx = (length == '0) ? IDLE : RUN;
      RUN:     if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // cfg capture; cfg_cnt selects address word (0) or length word (1)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ca_q       <= '0;
      cd_q       <= '0;
      cv_q       <= 1'b0;
      cfg_cnt    <= 1'b0;
      start_addr <= '0;
      length     <= '0;
      busy       <= 1'b0;
      axi_rready <= 1'b0;
    end else begin
      ca_q       <= cfg_addr;
      cd_q       <= cfg_data;
      cv_q       <= cfg_valid;
      busy       <= (state_nx == RUN);
      axi_rready <= 1'b1;   // beats outside RUN are swallowed so the bus never stalls
      if (state == IDLE) cfg_cnt <= 1'b0;
      else if (state == CONFIG && cfg_wr) begin
        cfg_cnt <= ~cfg_cnt;
        if (!cfg_cnt) start_addr <= cd_q;
        else          length     <= cd_q;
      end
    end
  end

  // AR generation and credit accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi_arvalid <= 1'b0;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
      ar_beats    <= '0;
      cur_addr    <= '0;
      beats_rem   <= '0;
      used        <= '0;
    end else if (state == START) begin
      axi_arvalid <= 1'b0;
      cur_addr    <= AXI_ADDR_WIDTH'(start_addr);
      beats_rem   <= beats_total;
      used        <= '0;
    end else begin
      if (axi_arvalid) begin
        if (axi_arready) begin
          axi_arvalid <= 1'b0;
          cur_addr    <= cur_addr + AXI_ADDR_WIDTH'(ar_beats) * AXI_ADDR_WIDTH'(BYTES);
          beats_rem   <= beats_rem - CW'(ar_beats);
        end
      end else if (state == RUN && beats_rem != '0 && free >= burst) begin
        axi_arvalid <= 1'b1;
        axi_araddr  <= cur_addr;
        axi_arlen   <= AXI_LEN_WIDTH'(burst - PW'(1));
        ar_beats    <= burst;
      end
      used <= used + (ar_hs ? ar_beats : '0) - (pop ? PW'(1) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[BUF_AWIDTH-1:0]] <= axi_rdata;
  end

  // buffer pointers and registered down-converter output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      ld_ptr   <= '0;
      ld_lane  <= '0;
      ld_words <= '0;
      acc_rem  <= '0;
      valid    <= 1'b0;
      data     <= '0;
      out_last <= 1'b0;
    end else if (state == START) begin
      wr_ptr   <= '0;
      ld_ptr   <= '0;
      ld_lane  <= '0;
      ld_words <= length;
      acc_rem  <= length;
      valid    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (ld_go) begin
        valid    <= 1'b1;
        data     <= ld_beat[int'(ld_lane)*DATA_WIDTH +: DATA_WIDTH];
        out_last <= ld_last;
        ld_words <= ld_words - CW'(1);
        if (ld_last) begin
          ld_ptr  <= ld_ptr + PW'(1);
          ld_lane <= '0;
        end else begin
          ld_lane <= ld_lane + LW'(1);
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (valid && ready) acc_rem <= acc_rem - CW'(1);
    end
  end

endmodule
